// File: rtl/apb_pkg.sv
// Shared APB definitions for the memory completer: bus widths, FSM state type
// and the address range helper.
package apb_pkg;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } apb_state_e;

  function automatic logic addr_in_range(input logic [APB_ADDR_W-1:0] addr,
                                         input int unsigned depth);
    logic [APB_ADDR_W:0] lim;
    lim = depth[APB_ADDR_W:0];
    return ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB completer-side bus bundle; the bridge drives the master modport and
// the memory completer uses the slave modport.
interface apb_slave_mem_if;
  import apb_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic                  pready;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_slv_regfile.sv
// DEPTH x 32 flop array with asynchronous clear, one write port and one
// combinational read port; addresses >= DEPTH read as 0 and never write.
module apb_slv_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 24
) (
  input  logic                  pclk,
  input  logic                  Reset_n,
  input  logic                  wr_en,
  input  logic [APB_ADDR_W-1:0] wr_addr,
  input  logic [APB_DATA_W-1:0] wr_data,
  input  logic [APB_ADDR_W-1:0] rd_addr,
  output logic [APB_DATA_W-1:0] rd_data
);

  logic [APB_DATA_W-1:0] mem_r [DEPTH];

  // Storage array: cleared on reset, one word written per enabled cycle
  always_ff @(posedge pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {APB_DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_addr == APB_ADDR_W'(i))) begin
          mem_r[i] <= wr_data;
        end
      end
    end
  end

  // Read mux; the decode only covers implemented words, so others give 0
  always_comb begin
    rd_data = {APB_DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == APB_ADDR_W'(i)) begin
        rd_data = mem_r[i];
      end else begin
        rd_data = rd_data;
      end
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a small register memory and programmable wait states.
// Optional APB_SLAVE_MEM_PSLVERR_EN flags out-of-range accesses on pslverr.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DEPTH       = 24,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            pclk,
  input  logic            Reset_n,
  apb_slave_mem_if.slave  bus
);

  apb_state_e            state_r;
  logic [3:0]            cnt_r;
  logic [APB_ADDR_W-1:0] addr_r;
  logic                  write_r;
  logic [APB_DATA_W-1:0] wdata_r;
  logic [APB_DATA_W-1:0] prdata_r;
  logic [APB_DATA_W-1:0] rd_data_s;
  logic                  pready_s;
  logic                  in_range_s;
  logic                  wr_en_s;
  logic                  pslverr_s;

  assign pready_s   = (state_r == S_ACCESS) && bus.psel && bus.penable &&
                      (cnt_r == 4'd0);
  assign in_range_s = addr_in_range(addr_r, DEPTH);
  assign wr_en_s    = pready_s && write_r && in_range_s;

`ifdef APB_SLAVE_MEM_PSLVERR_EN
  assign pslverr_s = pready_s && !in_range_s;
`else
  assign pslverr_s = 1'b0;
`endif

  // Memory is read at setup from the live address, so a write completing
  // in the previous cycle is always visible to the next read.
  apb_slv_regfile #(
    .DEPTH (DEPTH)
  ) u_regfile (
    .pclk    (pclk),
    .Reset_n (Reset_n),
    .wr_en   (wr_en_s),
    .wr_addr (addr_r),
    .wr_data (wdata_r),
    .rd_addr (bus.paddr),
    .rd_data (rd_data_s)
  );

  // Transfer FSM: setup latching, wait-state countdown, completion or abort
  always_ff @(posedge pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r  <= S_IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= {APB_ADDR_W{1'b0}};
      write_r  <= 1'b0;
      wdata_r  <= {APB_DATA_W{1'b0}};
      prdata_r <= {APB_DATA_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.psel && !bus.penable) begin
            addr_r   <= bus.paddr;
            write_r  <= bus.pwrite;
            wdata_r  <= bus.pwdata;
            prdata_r <= rd_data_s;
            cnt_r    <= 4'(WAIT_CYCLES);
            state_r  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!bus.psel) begin
            state_r <= S_IDLE;
          end else if (bus.penable) begin
            if (cnt_r != 4'd0) begin
              cnt_r <= cnt_r - 4'd1;
            end else begin
              state_r <= S_IDLE;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pready  = pready_s;
  assign bus.prdata  = prdata_r;
  assign bus.pslverr = pslverr_s;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench: a zero-wait and a three-wait completer driven with
// directed and random transfers against an array model of the memory.
module tb_apb_slave_mem;
  import apb_pkg::*;

  localparam int DEPTH = 24;

  logic pclk;
  logic Reset_n;

  apb_slave_mem_if bus0 ();
  apb_slave_mem_if bus1 ();

  apb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .Reset_n(Reset_n), .bus(bus0)
  );
  apb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
    .pclk(pclk), .Reset_n(Reset_n), .bus(bus1)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int unsigned assert_cnt = 0;
  int unsigned fail_cnt   = 0;
  logic [31:0] model_mem [2][32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int dev, input logic s, input logic e, input logic w,
                     input logic [4:0] a, input logic [31:0] d);
    if (dev == 0) begin
      bus0.psel = s; bus0.penable = e; bus0.pwrite = w; bus0.paddr = a; bus0.pwdata = d;
    end else begin
      bus1.psel = s; bus1.penable = e; bus1.pwrite = w; bus1.paddr = a; bus1.pwdata = d;
    end
  endtask

  task automatic smp(input int dev, output logic r, output logic [31:0] rd, output logic err);
    if (dev == 0) begin
      r = bus0.pready; rd = bus0.prdata; err = bus0.pslverr;
    end else begin
      r = bus1.pready; rd = bus1.prdata; err = bus1.pslverr;
    end
  endtask

  function automatic logic exp_err(input logic [4:0] a);
`ifdef APB_SLAVE_MEM_PSLVERR_EN
    return (int'(a) >= DEPTH);
`else
    return 1'b0 & a[0];
`endif
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) model_mem[d][i] = 32'd0;
  endtask

  task automatic idle(input int dev);
    @(negedge pclk);
    drv(dev, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  // One APB transfer; abort_k >= 0 drops psel in that access cycle.
  task automatic xfer(input int dev, input logic w, input logic [4:0] a,
                      input logic [31:0] d, input int abort_k);
    int          wc;
    logic        r, err;
    logic [31:0] rd, exp_rd;
    wc     = (dev == 0) ? 0 : 3;
    exp_rd = (int'(a) < DEPTH) ? model_mem[dev][a] : 32'd0;
    @(negedge pclk);
    drv(dev, 1'b1, 1'b0, w, a, d);
    #1 smp(dev, r, rd, err);
    check("setup_pready", {31'd0, r}, 32'd0);
    @(posedge pclk);
    for (int k = 0; k <= wc; k++) begin
      @(negedge pclk);
      if (k == abort_k) begin
        drv(dev, 1'b0, 1'b0, w, a, d);
        #1 smp(dev, r, rd, err);
        check("abort_pready", {31'd0, r}, 32'd0);
        @(posedge pclk);
        return;
      end
      drv(dev, 1'b1, 1'b1, w, a, w ? 32'hFFFF_FFFF : d);
      #1 smp(dev, r, rd, err);
      check("access_pready", {31'd0, r}, (k == wc) ? 32'd1 : 32'd0);
      if (k == wc) begin
        check("pslverr", {31'd0, err}, {31'd0, exp_err(a)});
        if (!w) check("prdata", rd, exp_rd);
      end
      @(posedge pclk);
    end
    if (w && int'(a) < DEPTH) model_mem[dev][a] = d;
  endtask

  initial begin
    logic        r, err;
    logic [31:0] rd;
    int          dev, ak;
    logic        w;
    logic [4:0]  a;

    clear_model();
    Reset_n = 1'b0;
    drv(0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    drv(1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(negedge pclk);
    for (int dv = 0; dv < 2; dv++) begin
      smp(dv, r, rd, err);
      check("reset_outputs", {rd[29:0], r, err}, 32'd0);
    end
    Reset_n = 1'b1;

    // Zero-wait write then read
    xfer(0, 1'b1, 5'd3, 32'hDEAD_BEEF, -1);
    xfer(0, 1'b0, 5'd3, 32'd0, -1);
    idle(0);
    #1 smp(0, r, rd, err);
    check("prdata_hold", rd, 32'hDEAD_BEEF);

    // Wait states: read address 0 after reset
    xfer(1, 1'b0, 5'd0, 32'd0, -1);

    // penable without setup is ignored
    @(negedge pclk);
    drv(1, 1'b1, 1'b1, 1'b1, 5'd4, 32'h1234_5678);
    repeat (3) begin
      #1 smp(1, r, rd, err);
      check("no_setup_pready", {31'd0, r}, 32'd0);
      @(negedge pclk);
    end
    drv(1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Back-to-back writes then reads
    xfer(1, 1'b1, 5'd5, 32'h11, -1);
    xfer(1, 1'b1, 5'd6, 32'h22, -1);
    xfer(1, 1'b0, 5'd5, 32'd0, -1);
    xfer(1, 1'b0, 5'd6, 32'd0, -1);
    check("b2b_model5", model_mem[1][5], 32'h11);

    // Out of range on both completers
    for (int dv = 0; dv < 2; dv++) begin
      xfer(dv, 1'b1, 5'd30, 32'hA5, -1);
      xfer(dv, 1'b0, 5'd30, 32'd0, -1);
      xfer(dv, 1'b0, 5'd6, 32'd0, -1);
    end

    // Abort during wait states
    xfer(1, 1'b1, 5'd2, 32'h77, 1);
    idle(1);
    xfer(1, 1'b0, 5'd2, 32'd0, -1);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      dev = int'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      a   = 5'($urandom_range(0, 31));
      ak  = (dev == 1 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
      xfer(dev, w, a, $urandom, ak);
      if ($urandom_range(0, 3) == 0) idle(dev);
    end
    for (int i = 0; i < 32; i += 5) begin
      xfer(0, 1'b0, 5'(i), 32'd0, -1);
      xfer(1, 1'b0, 5'(i), 32'd0, -1);
    end

    // Reset in the middle of an access phase
    idle(1);
    xfer(1, 1'b1, 5'd7, 32'h5A5A_5A5A, -1);
    @(negedge pclk);
    drv(1, 1'b1, 1'b0, 1'b1, 5'd8, 32'hCAFE_F00D);
    @(negedge pclk);
    drv(1, 1'b1, 1'b1, 1'b1, 5'd8, 32'hCAFE_F00D);
    @(negedge pclk);
    Reset_n = 1'b0;
    #1 smp(1, r, rd, err);
    check("rst_mid_outputs", {rd[29:0], r, err}, 32'd0);
    check("rst_mid_state", 32'(u_dut1.state_r), 32'(S_IDLE));
    clear_model();
    @(negedge pclk);
    drv(1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    Reset_n = 1'b1;
    xfer(1, 1'b0, 5'd8, 32'd0, -1);
    xfer(1, 1'b0, 5'd7, 32'd0, -1);

    idle(0);
    idle(1);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
